read_interface: RTL

Read-side counterpart of the FIFO write path; it drains the shared dual-port memory.
- Owns the read pointer and compares it with the write side's extended write address to derive empty.
- Issues synchronous memory reads with 1-cycle latency.
- Presents data on a first-word-fall-through valid/ready interface, backed by a 2-entry output buffer so one word per cycle is sustained under continuous read_ready.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/read_pointer.sv | 36 +++
 rtl/read_interface.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the write and read sides of the dual-port memory.
package fifo_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_ADDR_WIDTH = 10;
   localparam int unsigned DEPTH              = 2 ** DEFAULT_ADDR_WIDTH;
   localparam int unsigned OUTBUF_DEPTH       = 2;

   // Pointer carries one extra wrap bit above the memory index.
   typedef logic [DEFAULT_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/read_pointer.sv
// Read pointer counter: increment per issued read, synchronous load for flush.
module read_pointer #(
   parameter int unsigned WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] ptr
);

   logic [WIDTH-1:0] ptr_q;
   logic [WIDTH-1:0] ptr_d;

   // Load wins over increment so a flush never advances past the write pointer.
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = load_value;
      end else if (inc) begin
         ptr_d = ptr_q + {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/read_interface.sv
// FIFO read side: owns the read pointer, issues 1-cycle-latency memory reads and presents
// data through a 2-entry first-word-fall-through output buffer.
module read_interface
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH:0]   write_addr,
   output logic                  mem_read_en,
   output logic [ADDR_WIDTH:0]   read_addr,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   input  logic                  flush,
   input  logic                  read_ready,
   output logic                  read_valid,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  empty
);

   logic [ADDR_WIDTH:0]   read_ptr;
   logic                  inflight_q;
   logic [1:0]            count_q;
   logic [1:0]            count_d;
   logic                  head_q;
   logic                  tail_q;
   logic [DATA_WIDTH-1:0] entry_q [OUTBUF_DEPTH];
   logic                  pop;
   logic                  write_in;
   logic [2:0]            occupancy;

   assign empty      = (read_ptr == write_addr);
   assign read_valid = (count_q != 2'd0);
   assign read_data  = entry_q[head_q];
   assign read_addr  = read_ptr;
   assign pop        = read_valid && read_ready;

   // Buffered plus in-flight words after this cycle's pop; a slot must be free to issue.
   assign occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign mem_read_en = !rst && !empty && !flush && (occupancy < 3'(OUTBUF_DEPTH));

   // Data returning during a flush belongs to the discarded stream.
   assign write_in = inflight_q && !flush;

   read_pointer #(
      .WIDTH (ADDR_WIDTH + 1)
   ) u_read_pointer (
      .clk        (clk),
      .rst        (rst),
      .inc        (mem_read_en),
      .load       (flush),
      .load_value (write_addr),
      .ptr        (read_ptr)
   );

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         count_d = count_q + {1'b0, write_in} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q <= 1'b0;
         count_q    <= 2'd0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         for (int i = 0; i < OUTBUF_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         inflight_q <= mem_read_en;
         count_q    <= count_d;
         if (flush) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
         end else begin
            if (write_in) begin
               entry_q[tail_q] <= mem_read_data;
               tail_q          <= ~tail_q;
            end
            if (pop) begin
               head_q <= ~head_q;
            end
         end
      end
   end

endmodule
